line_buffer_7row: RTL and testbench

Raster-to-column line buffer that sits directly upstream of the 7x7 convolution stage. It accepts one 8-bit pixel per valid cycle in raster order. For every accepted pixel it emits a 56-bit column: the pixel plus the six pixels directly above it in the same image column. The output handshake connects straight to the convolution's `i_valid` / `i_data`, so the convolution's horizontal shift window sees vertically aligned 7-pixel columns.

---
 rtl/line_buffer_7row.sv | 119 +++++++++++
 tb/tb_line_buffer_7row.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_7row.sv
// line_buffer_7row
// Turns a raster pixel stream into vertically aligned 7-pixel columns for the
// 7x7 convolution. Six line memories form a vertical shift cascade, so row y-1
// sits in L0 and row y-6 in L5. Every accepted pixel also produces its column
// one cycle later, once the first six rows of the frame have been stored.

module line_buffer_7row #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic          i_sof,
    input  logic [7:0]    i_pixel,
    output logic          o_valid,
    output logic [55:0]   o_data,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);

    localparam int NLINES    = 6;
    localparam int WARM_ROWS = 6;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_WARM = YW'(WARM_ROWS);

    // Position of the next pixel to be accepted
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    // Line memories: index 0 holds row y-1, index 5 holds row y-6
    logic [7:0] line_mem [0:NLINES-1][0:IMG_W-1];

    // ---- stage p0: incoming pixel and its effective position ----
    logic          vld_p0;
    logic          sof_p0;
    logic [XW-1:0] x_p0;
    logic [YW-1:0] y_p0;
    logic          emit_p0;

    // ---- stage p1: registered column and its position ----
    logic          vld_p1;
    logic [55:0]   col_p1;
    logic [XW-1:0] x_p1;
    logic [YW-1:0] y_p1;

    // Start of frame overrides the counters so the flagged pixel lands on (0,0)
    always_comb begin
        vld_p0  = i_valid;
        sof_p0  = i_valid && i_sof;
        x_p0    = sof_p0 ? '0 : x;
        y_p0    = sof_p0 ? '0 : y;
        emit_p0 = vld_p0 && (y_p0 >= Y_WARM);
    end

    // Raster position counters, advanced once per accepted pixel with frame wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (vld_p0) begin
            if (x_p0 == X_LAST) begin
                x <= '0;
                if (y_p0 == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y_p0 + 1'b1;
                end
            end else begin
                x <= x_p0 + 1'b1;
                y <= y_p0;
            end
        end
    end

    // Vertical shift cascade: each line takes the old contents of the line above
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            line_mem[0][x_p0] <= i_pixel;
            for (int k = 1; k < NLINES; k++) begin
                line_mem[k][x_p0] <= line_mem[k-1][x_p0];
            end
        end
    end

    // Output strobe: one pulse per accepted pixel past the warm-up rows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= emit_p0;
        end
    end

    // Column capture; reads see pre-write contents, and data holds between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_p1 <= '0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else if (emit_p0) begin
            col_p1 <= {line_mem[5][x_p0], line_mem[4][x_p0], line_mem[3][x_p0],
                       line_mem[2][x_p0], line_mem[1][x_p0], line_mem[0][x_p0],
                       i_pixel};
            x_p1   <= x_p0;
            y_p1   <= y_p0;
        end
    end

    assign o_valid = vld_p1;
    assign o_data  = col_p1;
    assign o_x     = x_p1;
    assign o_y     = y_p1;

endmodule

// File: tb/tb_line_buffer_7row.sv
// Directed bench for line_buffer_7row with an 8x10 image whose pixel at (x,y)
// has value 16*y + x, so every expected column can be written down by hand.

module tb_line_buffer_7row;

    localparam int IMG_W = 8;
    localparam int IMG_H = 10;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    logic          clk;
    logic          reset;
    logic          i_valid;
    logic          i_sof;
    logic [7:0]    i_pixel;
    logic          o_valid;
    logic [55:0]   o_data;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;

    int n_cmp;
    int n_bad;
    int n_out;

    int mx;
    int my;
    logic [55:0] exp_data;
    int exp_x;
    int exp_y;

    line_buffer_7row #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_valid(i_valid),
        .i_sof  (i_sof),
        .i_pixel(i_pixel),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_x    (o_x),
        .o_y    (o_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (pos %0d,%0d)", tag, got, exp, mx, my);
        end
    endtask

    function automatic logic [55:0] col_at(input int cx, input int cy);
        logic [55:0] c;
        c = '0;
        for (int k = 0; k < 7; k++) begin
            c[8*k +: 8] = 8'((16 * (cy - k) + cx) & 255);
        end
        return c;
    endfunction

    // One clock: present (or withhold) the next raster pixel, then check outputs
    task automatic step(input bit v, input bit sof);
        bit ev;
        if (v && sof) begin
            mx = 0;
            my = 0;
        end
        @(negedge clk);
        i_valid = v;
        i_sof   = sof;
        i_pixel = 8'((16 * my + mx) & 255);
        @(posedge clk);
        #1;
        ev = v && (my >= 6);
        if (ev) begin
            exp_data = col_at(mx, my);
            exp_x    = mx;
            exp_y    = my;
            n_out++;
        end
        chk("o_valid", 64'(o_valid), 64'(ev));
        chk("o_data", 64'(o_data), 64'(exp_data));
        chk("o_x", 64'(o_x), 64'(exp_x));
        chk("o_y", 64'(o_y), 64'(exp_y));
        if (v) begin
            if (mx == IMG_W - 1) begin
                mx = 0;
                my = (my == IMG_H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_out = 0;
        mx = 0; my = 0;
        exp_data = '0; exp_x = 0; exp_y = 0;
        reset = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_pixel = 8'h00;

        // Reset held with i_valid toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_valid = (i % 2 == 0);
            i_pixel = 8'hA5;
            @(posedge clk);
            #1;
            chk("rst_valid", 64'(o_valid), 64'd0);
            chk("rst_data", 64'(o_data), 64'd0);
            chk("rst_x", 64'(o_x), 64'd0);
            chk("rst_y", 64'(o_y), 64'd0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        reset = 1'b1;

        // Frame A: warm-up, first column, steady state to the last pixel
        stream(48);
        chk("warm_silent", 64'(n_out), 64'd0);
        step(1'b1, 1'b0);
        chk("col_0_6", 64'(o_data), 64'h00_10_20_30_40_50_60);
        chk("col_0_6_y", 64'(o_y), 64'd6);
        stream(30);
        step(1'b1, 1'b0);
        chk("col_7_9", 64'(o_data), 64'h37_47_57_67_77_87_97);
        chk("col_7_9_x", 64'(o_x), 64'd7);
        chk("col_7_9_y", 64'(o_y), 64'd9);
        chk("frameA_count", 64'(n_out), 64'd32);

        // Frame B: same frame with idle gaps
        n_out = 0;
        for (int i = 0; i < 80; i++) begin
            while ($urandom_range(0, 9) < 4) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        chk("frameB_count", 64'(n_out), 64'd32);

        // Frame C: back-to-back, then a start-of-frame at (3,7)
        n_out = 0;
        stream(48);
        chk("frameC_silent", 64'(n_out), 64'd0);
        stream(11);
        chk("frameC_pre_sof", 64'(n_out), 64'd11);
        chk("sof_pos", 64'(my * 16 + mx), 64'h73);
        n_out = 0;
        step(1'b1, 1'b1);
        stream(47);
        chk("sof_silent", 64'(n_out), 64'd0);
        step(1'b1, 1'b0);
        chk("sof_resume_v", 64'(o_valid), 64'd1);
        chk("sof_resume_y", 64'(o_y), 64'd6);
        chk("sof_resume_d", 64'(o_data), 64'h00_10_20_30_40_50_60);
        stream(19);
        chk("pre_rst_pos", 64'(my * 16 + mx), 64'h84);

        // Asynchronous reset between edges while a column is being presented
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        #2;
        reset = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_data", 64'(o_data), 64'd0);
        chk("arst_x", 64'(o_x), 64'd0);
        chk("arst_y", 64'(o_y), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mx = 0; my = 0;
        exp_data = '0; exp_x = 0; exp_y = 0;
        n_out = 0;
        stream(48);
        chk("post_rst_silent", 64'(n_out), 64'd0);
        step(1'b1, 1'b0);
        chk("post_rst_v", 64'(o_valid), 64'd1);
        chk("post_rst_x", 64'(o_x), 64'd0);
        chk("post_rst_y", 64'(o_y), 64'd6);
        chk("post_rst_d", 64'(o_data), 64'h00_10_20_30_40_50_60);
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
